pcpi_m_router: RTL and testbench

- Sits between the core's single PCPI port and two M-extension coprocessors: the multiplier (MUL/MULH/MULHSU/MULHU, funct3[2]=0) and the divider (DIV/DIVU/REM/REMU, funct3[2]=1).
- Decodes each PCPI request, forwards it with registered copies of insn/rs1/rs2 to exactly one unit, and returns that unit's result to the core with a single-cycle pcpi_ready pulse.
- Suppresses re-dispatch while the core's pcpi_valid is still high after completion.

---
 rtl/pcpi_m_router.sv | 146 ++++++++++++++
 tb/tb_pcpi_m_router.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_m_router.sv
// PCPI router that steers M-extension requests to a multiplier or a divider and returns one result.
// Optional watchdog: define PCPI_M_ROUTER_TIMEOUT_EN to build the TIMEOUT_CYCLES completion timer.
module pcpi_m_router #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic        mul_valid,
    output logic        div_valid,
    output logic [31:0] cop_insn,
    output logic [31:0] cop_rs1,
    output logic [31:0] cop_rs2,
    input  logic        mul_wr,
    input  logic        mul_ready,
    input  logic        mul_wait,
    input  logic [31:0] mul_rd,
    input  logic        div_wr,
    input  logic        div_ready,
    input  logic        div_wait,
    input  logic [31:0] div_rd,
    output logic        err_timeout
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_sel;
    logic        r_mul_valid, r_div_valid, r_wait, r_ready, r_wr;
    logic [31:0] r_rd, r_insn, r_rs1, r_rs2;

    logic        w_match, w_accept, w_abort, w_done, w_timeout;
    logic        w_unit_ready, w_unit_wait, w_unit_wr;
    logic [31:0] w_unit_rd;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_BUSY;
            S_BUSY:  if (w_abort) w_next = S_IDLE;
                     else if (w_done || w_timeout) w_next = S_DRAIN;
            // a valid still held after completion must not start a second operation
            S_DRAIN: if (!pcpi_valid) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_match      = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
        w_unit_ready = r_sel ? div_ready : mul_ready;
        w_unit_wait  = r_sel ? div_wait  : mul_wait;
        w_unit_wr    = r_sel ? div_wr    : mul_wr;
        w_unit_rd    = r_sel ? div_rd    : mul_rd;
        w_accept     = (r_state == S_IDLE) && pcpi_valid && w_match;
        w_abort      = (r_state == S_BUSY) && !pcpi_valid;
        w_done       = (r_state == S_BUSY) && pcpi_valid && w_unit_ready;
    end

`ifdef PCPI_M_ROUTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // counter sits at zero outside BUSY, so it is cleared on every entry
    always_ff @(posedge clk) begin
        if (reset || r_state != S_BUSY) r_cnt <= '0;
        else                            r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)          r_err <= 1'b0;
        else if (w_timeout) r_err <= 1'b1;
    end

    assign w_timeout   = (r_state == S_BUSY) && pcpi_valid && !w_unit_ready &&
                         (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err_timeout = r_err;
`else
    assign w_timeout   = 1'b0;
    // constant 0; the parameter is referenced so both builds share one interface
    assign err_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel       <= 1'b0;
            r_mul_valid <= 1'b0;
            r_div_valid <= 1'b0;
            r_wait      <= 1'b0;
            r_ready     <= 1'b0;
            r_wr        <= 1'b0;
            r_rd        <= '0;
            r_insn      <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
        end else begin
            r_ready <= w_done || w_timeout;
            if (w_accept) begin
                r_insn      <= pcpi_insn;
                r_rs1       <= pcpi_rs1;
                r_rs2       <= pcpi_rs2;
                r_sel       <= pcpi_insn[14];
                r_mul_valid <= !pcpi_insn[14];
                r_div_valid <= pcpi_insn[14];
                r_wait      <= 1'b0;
            end else if (r_state == S_BUSY) begin
                if (w_abort || w_done || w_timeout) begin
                    r_mul_valid <= 1'b0;
                    r_div_valid <= 1'b0;
                    r_wait      <= 1'b0;
                end else begin
                    r_wait <= w_unit_wait;
                end
                if (w_done) begin
                    r_rd <= w_unit_rd;
                    r_wr <= w_unit_wr;
                end else if (w_timeout) begin
                    r_rd <= '0;
                    r_wr <= 1'b0;
                end
            end
        end
    end

    assign pcpi_wr    = r_wr;
    assign pcpi_rd    = r_rd;
    assign pcpi_wait  = r_wait;
    assign pcpi_ready = r_ready;
    assign mul_valid  = r_mul_valid;
    assign div_valid  = r_div_valid;
    assign cop_insn   = r_insn;
    assign cop_rs1    = r_rs1;
    assign cop_rs2    = r_rs2;
endmodule

// File: tb/tb_pcpi_m_router.sv
// Directed bench for pcpi_m_router: bench drives the unit responses by hand and checks each stage.
module tb_pcpi_m_router;
    logic        clk = 1'b0;
    logic        reset, pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr, pcpi_wait, pcpi_ready, mul_valid, div_valid, err_timeout;
    logic [31:0] pcpi_rd, cop_insn, cop_rs1, cop_rs2;
    logic        mul_wr, mul_ready, mul_wait, div_wr, div_ready, div_wait;
    logic [31:0] mul_rd, div_rd;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    pcpi_m_router #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready), .mul_valid(mul_valid),
        .div_valid(div_valid), .cop_insn(cop_insn), .cop_rs1(cop_rs1), .cop_rs2(cop_rs2),
        .mul_wr(mul_wr), .mul_ready(mul_ready), .mul_wait(mul_wait), .mul_rd(mul_rd),
        .div_wr(div_wr), .div_ready(div_ready), .div_wait(div_wait), .div_rd(div_rd),
        .err_timeout(err_timeout)
    );

    function automatic logic [31:0] m_insn(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // inputs change on the falling edge; outputs are read on the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet_units();
        mul_ready = 0; mul_wait = 0; mul_wr = 0; mul_rd = '0;
        div_ready = 0; div_wait = 0; div_wr = 0; div_rd = '0;
    endtask

    task automatic test_reset();
        reset = 1; pcpi_valid = 0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
        quiet_units();
        tick(); tick();
        checks++;
        if ({pcpi_wr, pcpi_wait, pcpi_ready, mul_valid, div_valid, err_timeout} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {pcpi_wr, pcpi_wait, pcpi_ready, mul_valid, div_valid, err_timeout});
        end
        checks++;
        if ({pcpi_rd, cop_insn, cop_rs1, cop_rs2} !== 128'b0) begin
            failures++;
            $display("FAIL reset_data got rd=%h insn=%h rs1=%h rs2=%h exp=0",
                     pcpi_rd, cop_insn, cop_rs1, cop_rs2);
        end
        reset = 0;
        tick();
    endtask

    task automatic test_div();
        pcpi_valid = 1; pcpi_insn = m_insn(3'b100); pcpi_rs1 = 32'd20; pcpi_rs2 = 32'd3;
        tick();
        checks++;
        if (div_valid !== 1'b1 || mul_valid !== 1'b0 || cop_rs1 !== 32'd20 || cop_rs2 !== 32'd3
            || cop_insn !== m_insn(3'b100)) begin
            failures++;
            $display("FAIL div_dispatch got dv=%b mv=%b rs1=%h rs2=%h exp dv=1 mv=0 rs1=14 rs2=3",
                     div_valid, mul_valid, cop_rs1, cop_rs2);
        end
        div_wait = 1;
        for (int i = 0; i < 32; i++) begin
            tick();
            checks++;
            if (div_valid !== 1'b1 || mul_valid !== 1'b0 || pcpi_wait !== 1'b1 || pcpi_ready !== 1'b0) begin
                failures++;
                $display("FAIL div_busy cyc=%0d got dv=%b mv=%b wait=%b rdy=%b exp 1 0 1 0",
                         i, div_valid, mul_valid, pcpi_wait, pcpi_ready);
            end
        end
        div_wait = 0; div_ready = 1; div_rd = 32'd6; div_wr = 1;
        tick();
        checks++;
        if (pcpi_ready !== 1'b1 || pcpi_rd !== 32'd6 || pcpi_wr !== 1'b1 || div_valid !== 1'b0
            || pcpi_wait !== 1'b0) begin
            failures++;
            $display("FAIL div_done got rdy=%b rd=%h wr=%b dv=%b wait=%b exp 1 6 1 0 0",
                     pcpi_ready, pcpi_rd, pcpi_wr, div_valid, pcpi_wait);
        end
        quiet_units(); pcpi_valid = 0;
        tick();
        checks++;
        if (pcpi_ready !== 1'b0 || pcpi_rd !== 32'd6 || pcpi_wr !== 1'b1) begin
            failures++;
            $display("FAIL div_pulse_end got rdy=%b rd=%h wr=%b exp 0 6 1", pcpi_ready, pcpi_rd, pcpi_wr);
        end
    endtask

    task automatic test_mul();
        logic [5:0] pat;
        pat = 6'b101101;
        pcpi_valid = 1; pcpi_insn = m_insn(3'b000); pcpi_rs1 = 32'd7; pcpi_rs2 = 32'hFFFF_FFFD;
        tick();
        checks++;
        if (mul_valid !== 1'b1 || div_valid !== 1'b0 || cop_rs2 !== 32'hFFFF_FFFD) begin
            failures++;
            $display("FAIL mul_dispatch got mv=%b dv=%b rs2=%h exp 1 0 fffffffd", mul_valid, div_valid, cop_rs2);
        end
        for (int i = 0; i < 6; i++) begin
            mul_wait = pat[i];
            div_ready = (i == 2); div_rd = 32'h1234_5678; div_wr = 1;
            tick();
            checks++;
            if (pcpi_wait !== pat[i] || mul_valid !== 1'b1 || div_valid !== 1'b0 || pcpi_ready !== 1'b0) begin
                failures++;
                $display("FAIL mul_wait cyc=%0d got wait=%b mv=%b dv=%b rdy=%b exp %b 1 0 0",
                         i, pcpi_wait, mul_valid, div_valid, pcpi_ready, pat[i]);
            end
        end
        quiet_units(); mul_ready = 1; mul_rd = 32'hFFFF_FFEB; mul_wr = 1;
        tick();
        checks++;
        if (pcpi_ready !== 1'b1 || pcpi_rd !== 32'hFFFF_FFEB || pcpi_wr !== 1'b1 || mul_valid !== 1'b0
            || pcpi_wait !== 1'b0) begin
            failures++;
            $display("FAIL mul_done got rdy=%b rd=%h wr=%b mv=%b wait=%b exp 1 ffffffeb 1 0 0",
                     pcpi_ready, pcpi_rd, pcpi_wr, mul_valid, pcpi_wait);
        end
        quiet_units(); pcpi_valid = 0;
        tick();
    endtask

    task automatic test_non_m();
        pcpi_valid = 1; pcpi_insn = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({mul_valid, div_valid, pcpi_ready, pcpi_wait} !== 4'b0) begin
                failures++;
                $display("FAIL non_m cyc=%0d got mv,dv,rdy,wait=%b exp 0000",
                         i, {mul_valid, div_valid, pcpi_ready, pcpi_wait});
            end
        end
        pcpi_valid = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        int episodes;
        logic prev_dv;
        episodes = 0; prev_dv = 0;
        pcpi_valid = 1; pcpi_insn = m_insn(3'b101); pcpi_rs1 = 32'hFFFF_FFFF; pcpi_rs2 = 32'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (div_valid && !prev_dv) episodes++;
            prev_dv = div_valid;
        end
        div_ready = 1; div_rd = 32'h7FFF_FFFF; div_wr = 1;
        tick();
        prev_dv = div_valid;
        checks++;
        if (pcpi_ready !== 1'b1 || pcpi_rd !== 32'h7FFF_FFFF) begin
            failures++;
            $display("FAIL divu_done got rdy=%b rd=%h exp 1 7fffffff", pcpi_ready, pcpi_rd);
        end
        quiet_units();
        for (int i = 0; i < 3; i++) begin
            tick();
            if (div_valid && !prev_dv) episodes++;
            prev_dv = div_valid;
            checks++;
            if (pcpi_ready !== 1'b0 || div_valid !== 1'b0 || pcpi_rd !== 32'h7FFF_FFFF) begin
                failures++;
                $display("FAIL stale_valid cyc=%0d got rdy=%b dv=%b rd=%h exp 0 0 7fffffff",
                         i, pcpi_ready, div_valid, pcpi_rd);
            end
        end
        checks++;
        if (episodes !== 1) begin
            failures++;
            $display("FAIL div_episodes got=%0d exp=1", episodes);
        end
        pcpi_valid = 0;
        tick();
        pcpi_valid = 1; pcpi_insn = m_insn(3'b011);
        tick();
        checks++;
        if (mul_valid !== 1'b1) begin
            failures++;
            $display("FAIL next_accept got mv=%b exp 1", mul_valid);
        end
        mul_ready = 1; mul_rd = 32'd1; mul_wr = 1;
        tick();
        quiet_units(); pcpi_valid = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        pcpi_valid = 1; pcpi_insn = m_insn(3'b110); pcpi_rs1 = 32'd17; pcpi_rs2 = 32'd5;
        for (int i = 0; i < 10; i++) tick();
        reset = 1; pcpi_valid = 0;
        tick();
        reset = 0; div_ready = 1; div_rd = 32'd2; div_wr = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({pcpi_ready, pcpi_wait, pcpi_wr, mul_valid, div_valid} !== 5'b0
                || pcpi_rd !== 32'd0 || cop_insn !== 32'd0) begin
                failures++;
                $display("FAIL reset_mid cyc=%0d got rdy,wait,wr,mv,dv=%b rd=%h insn=%h exp 0",
                         i, {pcpi_ready, pcpi_wait, pcpi_wr, mul_valid, div_valid}, pcpi_rd, cop_insn);
            end
        end
        quiet_units();
        pcpi_valid = 1; pcpi_insn = m_insn(3'b000);
        tick();
        checks++;
        if (mul_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_idle got mv=%b exp 1", mul_valid);
        end
        mul_ready = 1;
        tick();
        quiet_units(); pcpi_valid = 0;
        tick();
    endtask

    task automatic test_timeout();
        pcpi_valid = 1; pcpi_insn = m_insn(3'b100); pcpi_rs1 = 32'd9; pcpi_rs2 = 32'd0;
        tick();
`ifdef PCPI_M_ROUTER_TIMEOUT_EN
        for (int i = 1; i <= 16; i++) begin
            tick();
            checks++;
            if (pcpi_ready !== (i == 16)) begin
                failures++;
                $display("FAIL timeout_ready cyc=%0d got=%b exp=%b", i, pcpi_ready, (i == 16));
            end
        end
        checks++;
        if (pcpi_wr !== 1'b0 || pcpi_rd !== 32'd0 || err_timeout !== 1'b1 || div_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_done got wr=%b rd=%h err=%b dv=%b exp 0 0 1 0",
                     pcpi_wr, pcpi_rd, err_timeout, div_valid);
        end
        pcpi_valid = 0;
        tick(); tick();
        checks++;
        if (err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky got=%b exp=1", err_timeout);
        end
`else
        for (int i = 0; i < 200; i++) begin
            tick();
            checks++;
            if (pcpi_ready !== 1'b0 || err_timeout !== 1'b0 || div_valid !== 1'b1) begin
                failures++;
                $display("FAIL no_timeout cyc=%0d got rdy=%b err=%b dv=%b exp 0 0 1",
                         i, pcpi_ready, err_timeout, div_valid);
            end
        end
        pcpi_valid = 0;
        tick();
        checks++;
        if (div_valid !== 1'b0 || pcpi_ready !== 1'b0 || pcpi_wait !== 1'b0) begin
            failures++;
            $display("FAIL abort got dv=%b rdy=%b wait=%b exp 0 0 0", div_valid, pcpi_ready, pcpi_wait);
        end
`endif
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_div();
        test_mul();
        test_non_m();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
